// File: rtl/batch_norm_pipe.sv
// batch_norm_pipe: two-stage, multi-channel batch normalisation u_out = sat(u + addend[ch] + z*factor[ch]).
// Optional feature macro BN_SAT_COUNT_EN adds sat_clr/sat_count (count of clamped deliveries).
module batch_norm_pipe #(
   parameter int unsigned WIDTH        = 6,
   parameter int unsigned ADDEND_WIDTH = WIDTH - 2,
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned CH_BITS      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cfg_we,
   input  logic [CH_BITS-1:0]             cfg_ch,
   input  logic [3:0]                     cfg_factor,
   input  logic signed [ADDEND_WIDTH-1:0] cfg_addend,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CH_BITS-1:0]             in_ch,
   input  logic signed [WIDTH-1:0]        u,
   input  logic signed [WIDTH-1:0]        z,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CH_BITS-1:0]             out_ch,
   output logic signed [WIDTH-1:0]        u_out,
   output logic                           out_sat
`ifdef BN_SAT_COUNT_EN
   ,
   input  logic                           sat_clr,
   output logic [7:0]                     sat_count
`endif
);

   // Four guard bits cover the worst case x12 term plus u and addend.
   localparam int unsigned SW = WIDTH + 4;
   localparam logic [3:0] FACTOR_X1 = 4'b0100;
   localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (WIDTH - 1) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (WIDTH - 1)));

   logic [3:0]                     r_factor [CHANNELS];
   logic signed [ADDEND_WIDTH-1:0] r_addend [CHANNELS];

   logic                           r_s1_valid;
   logic [CH_BITS-1:0]             r_s1_ch;
   logic signed [SW-1:0]           r_s1_base;
   logic signed [SW-1:0]           r_s1_ta;
   logic signed [SW-1:0]           r_s1_tb;

   logic                           r_out_valid;
   logic [CH_BITS-1:0]             r_out_ch;
   logic signed [WIDTH-1:0]        r_u_out;
   logic                           r_out_sat;

   logic                           w_s2_adv;
   logic                           w_s1_adv;
   logic [3:0]                     w_factor;
   logic signed [ADDEND_WIDTH-1:0] w_addend;
   logic signed [SW-1:0]           w_zx;
   logic signed [SW-1:0]           w_term_a;
   logic signed [SW-1:0]           w_term_b;
   logic signed [SW-1:0]           w_base;
   logic signed [SW-1:0]           w_sum;
   logic signed [WIDTH-1:0]        w_sat_val;
   logic                           w_sat_flag;

   assign w_s2_adv = !r_out_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   // Config register file; out-of-range channel writes match no entry and are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            r_factor[c] <= FACTOR_X1;
            r_addend[c] <= '0;
         end
      end else if (cfg_we) begin
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (cfg_ch == CH_BITS'(c)) begin
               r_factor[c] <= cfg_factor;
               r_addend[c] <= cfg_addend;
            end
         end
      end
   end

   // Per-beat config lookup; unknown channels fall back to x1 / +0.
   always_comb begin
      w_factor = FACTOR_X1;
      w_addend = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (in_ch == CH_BITS'(c)) begin
            w_factor = r_factor[c];
            w_addend = r_addend[c];
         end
      end
   end

   assign w_zx   = SW'(z);
   assign w_base = SW'(u) + SW'(w_addend);

   always_comb begin
      w_term_a = '0;
      w_term_b = '0;
      case (w_factor[1:0])
         2'b01:   w_term_a = w_zx >>> 1;
         2'b10:   w_term_a = w_zx <<< 1;
         2'b11:   w_term_a = w_zx <<< 3;
         default: w_term_a = '0;
      endcase
      case (w_factor[3:2])
         2'b01:   w_term_b = w_zx;
         2'b10:   w_term_b = w_zx >>> 2;
         2'b11:   w_term_b = w_zx <<< 2;
         default: w_term_b = '0;
      endcase
   end

   // Stage 1: channel, u+addend and both shifted z terms.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_ch    <= '0;
         r_s1_base  <= '0;
         r_s1_ta    <= '0;
         r_s1_tb    <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_ch   <= in_ch;
            r_s1_base <= w_base;
            r_s1_ta   <= w_term_a;
            r_s1_tb   <= w_term_b;
         end
      end
   end

   assign w_sum = r_s1_base + r_s1_ta + r_s1_tb;

   always_comb begin
      w_sat_val  = w_sum[WIDTH-1:0];
      w_sat_flag = 1'b0;
      if (w_sum > SAT_MAX) begin
         w_sat_val  = {1'b0, {(WIDTH - 1){1'b1}}};
         w_sat_flag = 1'b1;
      end else if (w_sum < SAT_MIN) begin
         w_sat_val  = {1'b1, {(WIDTH - 1){1'b0}}};
         w_sat_flag = 1'b1;
      end
   end

   // Stage 2: saturated result, held while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_u_out     <= '0;
         r_out_sat   <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_ch  <= r_s1_ch;
            r_u_out   <= w_sat_val;
            r_out_sat <= w_sat_flag;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_ch    = r_out_ch;
   assign u_out     = r_u_out;
   assign out_sat   = r_out_sat;

`ifdef BN_SAT_COUNT_EN
   logic [7:0] r_sat_count;

   // Saturating count of clamped deliveries; clear has priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_count <= '0;
      end else if (sat_clr) begin
         r_sat_count <= '0;
      end else if (r_out_valid && out_ready && r_out_sat && (r_sat_count != 8'hFF)) begin
         r_sat_count <= r_sat_count + 8'd1;
      end
   end

   assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_batch_norm_pipe.sv
// tb_batch_norm_pipe: directed and random stimulus for batch_norm_pipe, scored against an arithmetic model.
// Build with BN_SAT_COUNT_EN defined to also exercise the saturation counter.
module tb_batch_norm_pipe;

   localparam int W    = 6;
   localparam int AW   = W - 2;
   localparam int CH   = 4;
   localparam int CHB  = 2;
   localparam int MAXV = 2 ** (W - 1) - 1;
   localparam int MINV = -(2 ** (W - 1));

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  cfg_we = 1'b0;
   logic [CHB-1:0]        cfg_ch = '0;
   logic [3:0]            cfg_factor = '0;
   logic signed [AW-1:0]  cfg_addend = '0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [CHB-1:0]        in_ch = '0;
   logic signed [W-1:0]   u = '0;
   logic signed [W-1:0]   z = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [CHB-1:0]        out_ch;
   logic signed [W-1:0]   u_out;
   logic                  out_sat;
`ifdef BN_SAT_COUNT_EN
   logic                  sat_clr = 1'b0;
   logic [7:0]            sat_count;
`endif

   batch_norm_pipe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_factor (cfg_factor),
      .cfg_addend (cfg_addend),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ch      (in_ch),
      .u          (u),
      .z          (z),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ch     (out_ch),
      .u_out      (u_out),
      .out_sat    (out_sat)
`ifdef BN_SAT_COUNT_EN
      ,
      .sat_clr    (sat_clr),
      .sat_count  (sat_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int u_out;
      int ch;
      int sat;
      int acc;
   } exp_t;

   exp_t q[$];
   int   m_factor [CH];
   int   m_addend [CH];
   int   n_total = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   last_acc = 0;
   bit   check_lat = 0;
   bit   use_force = 0;
   int   force_u = 0;
   int   force_sat = 0;
   bit   prev_stall = 0;
   int   hold_u, hold_ch, hold_sat;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int fdiv(input int a, input int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   // z * factor as the sum of two independently floored scaled terms.
   function automatic int scaled(input int zz, input int code);
      int t = 0;
      case (code % 4)
         1: t += fdiv(zz, 2);
         2: t += zz * 2;
         3: t += zz * 8;
         default: t += 0;
      endcase
      case (code / 4)
         1: t += zz;
         2: t += fdiv(zz, 4);
         3: t += zz * 4;
         default: t += 0;
      endcase
      return t;
   endfunction

   function automatic int model_sum(input int ch, input int uu, input int zz);
      int f = 4;
      int a = 0;
      if (ch < CH) begin
         f = m_factor[ch];
         a = m_addend[ch];
      end
      return uu + a + scaled(zz, f);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_factor[c] = 4;
         m_addend[c] = 0;
      end
   endtask

   // One clock: sample at the falling edge, score, then return just after the rising edge.
   task automatic tick();
      int   occ;
      int   v;
      exp_t e;
      @(negedge clk);
      cyc++;
      occ = q.size();
      last_acc = 0;
      chk("in_ready", int'(in_ready), int'((occ < 2) || out_ready));
      if (prev_stall) begin
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_u", int'(u_out), hold_u);
         chk("hold_ch", int'(out_ch), hold_ch);
         chk("hold_sat", int'(out_sat), hold_sat);
      end
      prev_stall = out_valid && !out_ready;
      hold_u   = int'(u_out);
      hold_ch  = int'(out_ch);
      hold_sat = int'(out_sat);
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_out", int'(out_valid), 0);
         end else begin
            e = q.pop_front();
            chk("u_out", int'(u_out), e.u_out);
            chk("out_ch", int'(out_ch), e.ch);
            chk("out_sat", int'(out_sat), e.sat);
            if (check_lat) chk("latency", cyc - e.acc, 2);
         end
      end
      if (in_valid && in_ready) begin
         v = model_sum(int'(in_ch), int'(u), int'(z));
         e.ch  = int'(in_ch);
         e.sat = ((v > MAXV) || (v < MINV)) ? 1 : 0;
         e.u_out = (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
         if (use_force) begin
            e.u_out = force_u;
            e.sat   = force_sat;
         end
         e.acc = cyc;
         q.push_back(e);
         last_acc = 1;
      end
      if (cfg_we && (int'(cfg_ch) < CH)) begin
         m_factor[cfg_ch] = int'(cfg_factor);
         m_addend[cfg_ch] = int'(cfg_addend);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input int uu, input int zz, input int eu, input int es);
      bit got = 0;
      use_force = 1;
      force_u   = eu;
      force_sat = es;
      in_valid  = 1'b1;
      in_ch     = CHB'(ch);
      u         = W'(uu);
      z         = W'(zz);
      for (int k = 0; k < 10 && !got; k++) begin
         tick();
         got = last_acc;
      end
      chk("accept", int'(got), 1);
      in_valid  = 1'b0;
      use_force = 0;
   endtask

   task automatic cfg_write(input int ch, input logic [3:0] f, input int a);
      cfg_we     = 1'b1;
      cfg_ch     = CHB'(ch);
      cfg_factor = f;
      cfg_addend = AW'(a);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && q.size() != 0; k++) tick();
      chk("drain", q.size(), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_u_out", int'(u_out), 0);
      chk("rst_out_ch", int'(out_ch), 0);
      chk("rst_out_sat", int'(out_sat), 0);
      chk("rst_in_ready", int'(in_ready), 1);
`ifdef BN_SAT_COUNT_EN
      chk("rst_sat_count", int'(sat_count), 0);
`endif
      q.delete();
      prev_stall = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int idx;
      bit saw_block;
      int bp_u [4] = '{1, -5, 7, -8};
      int bp_z [4] = '{2, 1, 7, -8};
      int bp_e [4] = '{3, -4, 14, -16};

      #2;
      do_reset();

      // Directed arithmetic with an always-ready sink.
      check_lat = 1;
      out_ready = 1'b1;
      drive(0, 5, 3, 8, 0);
      drain();
      cfg_write(1, 4'b0110, -2);
      drive(1, 4, 5, 17, 0);
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_factor = 4'b0100; cfg_addend = -4'sd2;
      in_valid = 1'b1; in_ch = 2'd1; u = 6'sd4; z = 6'sd5;
      use_force = 1; force_u = 17; force_sat = 0;
      tick();
      chk("samecyc_accept", int'(last_acc), 1);
      cfg_we = 1'b0; in_valid = 1'b0; use_force = 0;
      drive(1, 4, 5, 7, 0);
      cfg_write(2, 4'b0011, 0);
      drive(2, 10, 4, 31, 1);
      drive(2, -10, -4, -32, 1);
      cfg_write(2, 4'b1111, 0);
      drive(2, 0, 3, 31, 1);
      cfg_write(0, 4'b0001, 0);
      drive(0, 0, -3, -2, 0);
      cfg_write(0, 4'b1000, 0);
      drive(0, 0, -1, -1, 0);
      cfg_write(0, 4'b1001, 0);
      drive(0, 1, 4, 4, 0);
      drain();

      // Backpressure: four back-to-back beats while the sink stalls for three cycles.
      check_lat = 0;
      cfg_write(3, 4'b0100, 0);
      drain();
      idx = 0;
      saw_block = 0;
      use_force = 1;
      for (int k = 0; k < 30 && idx < 4; k++) begin
         out_ready = (k >= 3);
         in_valid  = 1'b1;
         in_ch     = 2'd3;
         u         = W'(bp_u[idx]);
         z         = W'(bp_z[idx]);
         force_u   = bp_e[idx];
         force_sat = 0;
         tick();
         if (!last_acc) saw_block = 1;
         if (last_acc) idx++;
      end
      in_valid  = 1'b0;
      use_force = 0;
      out_ready = 1'b1;
      chk("bp_accepted", idx, 4);
      chk("bp_in_ready_low", int'(saw_block), 1);
      drain();

      // Random traffic, config churn and backpressure.
      for (int i = 0; i < 500; i++) begin
         cfg_we     = ($urandom_range(0, 7) == 0);
         cfg_ch     = CHB'($urandom_range(0, CH - 1));
         cfg_factor = 4'($urandom);
         cfg_addend = AW'($urandom);
         in_valid   = ($urandom_range(0, 3) != 0);
         in_ch      = CHB'($urandom_range(0, CH - 1));
         u          = W'($urandom);
         z          = W'($urandom);
         out_ready  = ($urandom_range(0, 3) != 0);
         tick();
      end
      cfg_we    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Reset with two beats held in the pipe; nothing stale may come out afterwards.
      cfg_write(1, 4'b0110, -2);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_ch     = 2'd1;
      u         = 6'sd3;
      z         = 6'sd3;
      tick();
      tick();
      in_valid = 1'b0;
      chk("pre_rst_held", q.size(), 2);
      do_reset();
      out_ready = 1'b1;
      repeat (6) tick();
      check_lat = 1;
      drive(1, 4, 5, 9, 0);
      drain();

`ifdef BN_SAT_COUNT_EN
      cfg_write(2, 4'b0011, 0);
      for (int k = 0; k < 3; k++) drive(2, 10, 4, 31, 1);
      drain();
      chk("sat_count", int'(sat_count), 3);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      chk("sat_count_clr", int'(sat_count), 0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/batch_norm_pipe.md
Name: batch_norm_pipe

Overview:
- Multi-channel, pipelined successor to the single-channel combinational batch-normalisation stage.
- Computes u_out = sat(u + addend[ch] + z * factor[ch]) for one of CHANNELS neuron channels per beat.
- Per-channel factor and addend live in a config register file, written through a simple write port.
- Sits between the membrane-potential accumulator and the spike/threshold stage; valid/ready on input and output.

Parameters:
- WIDTH, 6, signed width of u, z and u_out.
- ADDEND_WIDTH, WIDTH-2, signed width of the per-channel addend.
- CHANNELS, 4, number of channels with independent config.
- CH_BITS, $clog2(CHANNELS) (min 1), width of channel index ports.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_BITS  channel to write
- cfg_factor  in  4  factor code
- cfg_addend  in  ADDEND_WIDTH  signed addend
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_ch  in  CH_BITS  channel of the beat
- u  in  WIDTH  signed membrane potential
- z  in  WIDTH  signed synaptic input
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_ch  out  CH_BITS  channel of the result
- u_out  out  WIDTH  saturated result
- out_sat  out  1  result was clamped

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, u_out=0, out_ch=0, out_sat=0, both stage-valid flags cleared.
  - Every channel's factor=4'b0100 (x1) and addend=0.
  - In-flight beats are discarded; in_ready=1 after reset.
- Config: on a clk edge with cfg_we=1, register[cfg_ch] is updated. A cfg_ch >= CHANNELS write is ignored.
- Config/data same cycle: a beat accepted in the same cycle as a write to its channel uses the OLD values. New values apply from the next accepted beat.
- Factor code, two fields summed:
  - [1:0]: 00 = 0, 01 = z>>>1, 10 = z<<1, 11 = z<<3.
  - [3:2]: 00 = 0, 01 = z, 10 = z>>>2, 11 = z<<2.
  - Right shifts are arithmetic (floor toward -inf).
- Arithmetic width:
  - Internal sum is WIDTH+4 signed bits, with all operands sign-extended.
  - No overflow is possible for any of the 16 codes, including x9, x8.25 and x12, and any addend. The old "factor<=8, addend=0 at x8" restriction is removed.
- Saturation:
  - sum > 2^(WIDTH-1)-1 gives the max value, out_sat=1.
  - sum < -2^(WIDTH-1) gives the min value, out_sat=1.
  - Otherwise u_out = sum[WIDTH-1:0] and out_sat=0.
- Pipeline, 2 stages, latency 2 cycles from accept to out_valid when unstalled:
  - S1 registers ch, u+addend and the two shifted z terms.
  - S2 registers the saturated result.
  - Throughput is 1 beat/cycle.
- Handshake:
  - A beat is accepted on in_valid & in_ready.
  - A beat is delivered on out_valid & out_ready.
  - s2_adv = !out_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
  - A stalled stage holds its contents stable. out_* stay stable while out_valid & !out_ready.
- Ordering and loss: beats are delivered in order with no drop or duplication. A full pipeline (2 beats) under out_ready=0 deasserts in_ready combinationally.
- Channel range: an in_ch >= CHANNELS beat uses factor x1 and addend 0, and still propagates with its in_ch.

Optional Feature:
- Macro: BN_SAT_COUNT_EN.
- When defined, adds ports:
  - sat_clr  in  1
  - sat_count  out  8
- sat_count increments on each delivered beat with out_sat=1, saturates at 255, and resets to 0.
- sat_clr=1 clears it synchronously; clear wins over a simultaneous increment.
- When not defined: no ports and no counter logic; the rest of the behaviour is identical.

Test Plan:
- Reset, then ch0 beat u=5, z=3, out_ready=1 -> u_out=8, out_sat=0, out_valid exactly 2 cycles after accept, out_ch=0.
- Write ch1 factor=0110 (x3), addend=-2; beat ch1 u=4, z=5 -> u_out=17. Same-cycle write ch1 factor=0100 with a beat u=4, z=5 -> 17 (old), next beat -> 7.
- Saturation, ch2 factor=0011 (x8):
  - u=10, z=4 -> u_out=31, out_sat=1.
  - u=-10, z=-4 -> -32, out_sat=1.
  - Code 1111 (x12), u=0, z=3 -> 31, out_sat=1.
- Floor rounding:
  - factor=0001, u=0, z=-3 -> -2.
  - factor=1000, u=0, z=-1 -> -1.
  - factor=1001, u=1, z=4 -> 4.
- Backpressure: 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready low once 2 beats are held, outputs stable, all 4 results delivered in order after out_ready=1.
- Reset mid-stream with 2 beats in flight -> out_valid=0 immediately, no stale result after release. With BN_SAT_COUNT_EN: 3 saturating deliveries -> sat_count=3; sat_clr -> 0.
